// File: rtl/clock_set_ctrl.sv
// Time/alarm setting controller for DigitalClock: button FSM, shadow edit registers and a load strobe.
// Optional alarm states, registers and alarm_out are built when CLOCK_SET_CTRL_ALARM_EN is defined.
module clock_set_ctrl #(
  parameter int AUTO_EXIT_SECS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_sec_pulse,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic [23:0] cur_time,
  output logic        load,
  output logic [23:0] load_time,
  output logic        clk_hold,
  output logic [23:0] disp_time,
  output logic        blink,
  output logic [2:0]  mode_state
`ifdef CLOCK_SET_CTRL_ALARM_EN
  ,
  output logic        alarm_out
`endif
);

  localparam logic [2:0] RUN      = 3'd0;
  localparam logic [2:0] SET_HOUR = 3'd1;
  localparam logic [2:0] SET_MIN  = 3'd2;
  localparam logic [2:0] ALM_HOUR = 3'd3;
  localparam logic [2:0] ALM_MIN  = 3'd4;

  localparam int CNT_W = (AUTO_EXIT_SECS > 1) ? $clog2(AUTO_EXIT_SECS + 1) : 1;
  localparam logic [CNT_W-1:0] EXIT_LAST = CNT_W'(AUTO_EXIT_SECS - 1);

  // Two-digit BCD increment that wraps to 00 after max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)             return 8'h00;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [2:0]       state_q, state_d;
  logic             mode_prev_q, inc_prev_q;
  logic [7:0]       sh_hour_q, sh_hour_d, sh_min_q, sh_min_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;
  logic             load_q, load_d;
  logic [23:0]      load_time_q, load_time_d;
  logic             clk_hold_q, clk_hold_d;
  logic [23:0]      disp_q, disp_d;
  logic             mode_edge, inc_edge, any_edge, alarm_ack;
`ifdef CLOCK_SET_CTRL_ALARM_EN
  logic [7:0]       al_hour_q, al_hour_d, al_min_q, al_min_d;
  logic             alarm_q, alarm_d;
`endif

  always_comb begin
    mode_edge   = mode_btn & ~mode_prev_q;
    inc_edge    = inc_btn & ~inc_prev_q;
    any_edge    = mode_edge | inc_edge;
    alarm_ack   = 1'b0;
    state_d     = state_q;
    sh_hour_d   = sh_hour_q;
    sh_min_d    = sh_min_q;
    cnt_d       = cnt_q;
    load_d      = 1'b0;
    load_time_d = load_time_q;
`ifdef CLOCK_SET_CTRL_ALARM_EN
    al_hour_d   = al_hour_q;
    al_min_d    = al_min_q;
    alarm_d     = alarm_q;
    // A button edge while the alarm rings only acknowledges it.
    if (alarm_q && any_edge) begin
      alarm_d   = 1'b0;
      alarm_ack = 1'b1;
    end else if (state_q == RUN && one_sec_pulse &&
                 cur_time == {al_hour_q, al_min_q, 8'h00}) begin
      alarm_d = 1'b1;
    end
`endif
    if (!alarm_ack) begin
      if (mode_edge) begin
        case (state_q)
          RUN: begin
            state_d   = SET_HOUR;
            sh_hour_d = cur_time[23:16];
            sh_min_d  = cur_time[15:8];
          end
          SET_HOUR: state_d = SET_MIN;
          SET_MIN: begin
`ifdef CLOCK_SET_CTRL_ALARM_EN
            state_d = ALM_HOUR;
`else
            state_d = RUN;
`endif
            load_d      = 1'b1;
            load_time_d = {sh_hour_q, sh_min_q, 8'h00};
          end
`ifdef CLOCK_SET_CTRL_ALARM_EN
          ALM_HOUR: state_d = ALM_MIN;
          ALM_MIN:  state_d = RUN;
`endif
          default:  state_d = RUN;
        endcase
      end else if (inc_edge) begin
        case (state_q)
          SET_HOUR: sh_hour_d = bcd_inc(sh_hour_q, 8'h23);
          SET_MIN:  sh_min_d  = bcd_inc(sh_min_q, 8'h59);
`ifdef CLOCK_SET_CTRL_ALARM_EN
          ALM_HOUR: al_hour_d = bcd_inc(al_hour_q, 8'h23);
          ALM_MIN:  al_min_d  = bcd_inc(al_min_q, 8'h59);
`endif
          default: ;
        endcase
      end else if (one_sec_pulse && state_q != RUN) begin
        if (AUTO_EXIT_SECS != 0 && cnt_q == EXIT_LAST) state_d = RUN;
        else cnt_d = cnt_q + 1'b1;
      end
    end
    if (any_edge || state_d != state_q || state_d == RUN) cnt_d = '0;

    if (state_d == RUN)          blink_d = 1'b0;
    else if (state_d != state_q) blink_d = 1'b1;
    else if (one_sec_pulse)      blink_d = ~blink_q;
    else                         blink_d = blink_q;

    clk_hold_d = (state_d == SET_HOUR) || (state_d == SET_MIN);

    case (state_d)
      SET_HOUR, SET_MIN: disp_d = {sh_hour_d, sh_min_d, 8'h00};
`ifdef CLOCK_SET_CTRL_ALARM_EN
      ALM_HOUR, ALM_MIN: disp_d = {al_hour_d, al_min_d, 8'h00};
`endif
      default:           disp_d = cur_time;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      sh_hour_q   <= 8'h00;
      sh_min_q    <= 8'h00;
      cnt_q       <= '0;
      blink_q     <= 1'b0;
      load_q      <= 1'b0;
      load_time_q <= 24'h0;
      clk_hold_q  <= 1'b0;
      disp_q      <= 24'h0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_btn;
      inc_prev_q  <= inc_btn;
      sh_hour_q   <= sh_hour_d;
      sh_min_q    <= sh_min_d;
      cnt_q       <= cnt_d;
      blink_q     <= blink_d;
      load_q      <= load_d;
      load_time_q <= load_time_d;
      clk_hold_q  <= clk_hold_d;
      disp_q      <= disp_d;
    end
  end

`ifdef CLOCK_SET_CTRL_ALARM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      al_hour_q <= 8'h06;
      al_min_q  <= 8'h00;
      alarm_q   <= 1'b0;
    end else begin
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
      alarm_q   <= alarm_d;
    end
  end

  assign alarm_out = alarm_q;
`endif

  assign load       = load_q;
  assign load_time  = load_time_q;
  assign clk_hold   = clk_hold_q;
  assign disp_time  = disp_q;
  assign blink      = blink_q;
  assign mode_state = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl (AUTO_EXIT_SECS=3); alarm checks build when CLOCK_SET_CTRL_ALARM_EN is defined.
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        one_sec_pulse = 1'b0;
  logic        mode_btn = 1'b0;
  logic        inc_btn = 1'b0;
  logic [23:0] cur_time = 24'h0;
  logic        load;
  logic [23:0] load_time;
  logic        clk_hold;
  logic [23:0] disp_time;
  logic        blink;
  logic [2:0]  mode_state;
`ifdef CLOCK_SET_CTRL_ALARM_EN
  logic        alarm_out;
`endif

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;

  clock_set_ctrl #(.AUTO_EXIT_SECS(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .one_sec_pulse (one_sec_pulse),
    .mode_btn      (mode_btn),
    .inc_btn       (inc_btn),
    .cur_time      (cur_time),
    .load          (load),
    .load_time     (load_time),
    .clk_hold      (clk_hold),
    .disp_time     (disp_time),
    .blink         (blink),
    .mode_state    (mode_state)
`ifdef CLOCK_SET_CTRL_ALARM_EN
    ,
    .alarm_out     (alarm_out)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load) load_cnt <= load_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release both buttons for a cycle, then raise the requested ones across one edge.
  task automatic press(input logic m, input logic i);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    tick();
    mode_btn = m;
    inc_btn  = i;
    tick();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  task automatic sec_pulse();
    one_sec_pulse = 1'b1;
    tick();
    one_sec_pulse = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    cur_time = 24'h123456;
    do_reset();
    chk("rst_state", 32'(mode_state), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_hold", 32'(clk_hold), 32'd0);
    chk("rst_blink", 32'(blink), 32'd0);
    chk("rst_ltime", 32'(load_time), 32'h000000);
`ifdef CLOCK_SET_CTRL_ALARM_EN
    chk("rst_alarm", 32'(alarm_out), 32'd0);
`endif
    tick();
    chk("run_disp", 32'(disp_time), 32'h123456);

    // 12:34 -> 15:36 full edit
    press(1'b1, 1'b0);
    chk("t1_state_sh", 32'(mode_state), 32'd1);
    chk("t1_hold_sh", 32'(clk_hold), 32'd1);
    chk("t1_blink_sh", 32'(blink), 32'd1);
    chk("t1_disp_sh", 32'(disp_time), 32'h123400);
    repeat (3) press(1'b0, 1'b1);
    chk("t1_disp_h15", 32'(disp_time), 32'h153400);
    press(1'b1, 1'b0);
    chk("t1_state_sm", 32'(mode_state), 32'd2);
    chk("t1_hold_sm", 32'(clk_hold), 32'd1);
    chk("t1_load_sm", 32'(load), 32'd0);
    repeat (2) press(1'b0, 1'b1);
    chk("t1_disp_m36", 32'(disp_time), 32'h153600);
    press(1'b1, 1'b0);
`ifdef CLOCK_SET_CTRL_ALARM_EN
    chk("t1_state_exit", 32'(mode_state), 32'd3);
`else
    chk("t1_state_exit", 32'(mode_state), 32'd0);
    chk("t1_blink_exit", 32'(blink), 32'd0);
`endif
    chk("t1_load", 32'(load), 32'd1);
    chk("t1_ltime", 32'(load_time), 32'h153600);
    chk("t1_hold_exit", 32'(clk_hold), 32'd0);
    tick();
    chk("t1_load_drop", 32'(load), 32'd0);
    chk("t1_ltime_hold", 32'(load_time), 32'h153600);
    chk("t1_load_cnt", 32'(load_cnt), 32'd1);

    // Wrap: hour 23 -> 00 -> 01, minute 59 -> 00
    do_reset();
    load_cnt = 0;
    cur_time = 24'h235900;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t2_hour_wrap", 32'(disp_time), 32'h005900);
    press(1'b0, 1'b1);
    chk("t2_hour_01", 32'(disp_time), 32'h015900);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t2_min_wrap", 32'(disp_time), 32'h010000);
    press(1'b1, 1'b0);
    chk("t2_ltime", 32'(load_time), 32'h010000);
    tick();
    chk("t2_load_cnt", 32'(load_cnt), 32'd1);

    // Timeout after 3 seconds with no buttons
    do_reset();
    load_cnt = 0;
    cur_time = 24'h094500;
    tick();
    press(1'b1, 1'b0);
    chk("t3_state_sh", 32'(mode_state), 32'd1);
    sec_pulse();
    chk("t3_blink_tog", 32'(blink), 32'd0);
    sec_pulse();
    chk("t3_state_2s", 32'(mode_state), 32'd1);
    chk("t3_blink_2s", 32'(blink), 32'd1);
    sec_pulse();
    chk("t3_state_run", 32'(mode_state), 32'd0);
    chk("t3_hold", 32'(clk_hold), 32'd0);
    chk("t3_blink", 32'(blink), 32'd0);
    chk("t3_load", 32'(load), 32'd0);
    tick();
    chk("t3_load_cnt", 32'(load_cnt), 32'd0);
    chk("t3_ltime", 32'(load_time), 32'h000000);
    chk("t3_disp", 32'(disp_time), 32'h094500);

    // BCD carry 09 -> 10, then simultaneous mode+inc
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t4_carry", 32'(disp_time), 32'h104500);
    press(1'b1, 1'b1);
    chk("t4_state", 32'(mode_state), 32'd2);
    chk("t4_disp", 32'(disp_time), 32'h104500);
    chk("t4_blink", 32'(blink), 32'd1);

    // Reset mid-edit in SET_MIN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_state", 32'(mode_state), 32'd0);
    chk("t5_load", 32'(load), 32'd0);
    chk("t5_hold", 32'(clk_hold), 32'd0);
    chk("t5_blink", 32'(blink), 32'd0);
    tick();
    chk("t5_load_cnt", 32'(load_cnt), 32'd0);

    // inc in RUN is ignored
    press(1'b0, 1'b1);
    chk("t6_state", 32'(mode_state), 32'd0);
    chk("t6_hold", 32'(clk_hold), 32'd0);
    chk("t6_disp", 32'(disp_time), 32'h094500);

`ifdef CLOCK_SET_CTRL_ALARM_EN
    // Alarm 06:00 -> 06:01, then ring and acknowledge
    do_reset();
    cur_time = 24'h120000;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("t7_state_ah", 32'(mode_state), 32'd3);
    chk("t7_disp_ah", 32'(disp_time), 32'h060000);
    chk("t7_hold_ah", 32'(clk_hold), 32'd0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t7_disp_am", 32'(disp_time), 32'h060100);
    press(1'b1, 1'b0);
    chk("t7_state_run", 32'(mode_state), 32'd0);
    cur_time = 24'h060100;
    tick();
    chk("t7_alarm_idle", 32'(alarm_out), 32'd0);
    sec_pulse();
    chk("t7_alarm_set", 32'(alarm_out), 32'd1);
    press(1'b0, 1'b1);
    chk("t7_alarm_clr", 32'(alarm_out), 32'd0);
    chk("t7_state_ack", 32'(mode_state), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter AUTO_EXIT_SECS, default 30: count of one_sec_pulse with no button edge before a set state is abandoned; 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port one_sec_pulse  input  1  one-cycle strobe per simulated second from DigitalClock.
REQ-005 SHALL have port mode_btn  input  1  debounced, synchronous level input for mode/advance.
REQ-006 SHALL have port inc_btn  input  1  debounced, synchronous level input for increment.
REQ-007 SHALL have port cur_time  input  24  packed BCD {hour_tens,hour_ones,min_tens,min_ones,sec_tens,sec_ones}, 4 bits each, from DigitalClock.
REQ-008 SHALL have port load  output  1  one-cycle strobe telling DigitalClock to take load_time.
REQ-009 SHALL have port load_time  output  24  packed BCD value to load, same layout as cur_time.
REQ-010 SHALL have port clk_hold  output  1  high freezes DigitalClock counting.
REQ-011 SHALL have port disp_time  output  24  packed BCD value for the display.
REQ-012 SHALL have port blink  output  1  display blank/blink phase for the field being edited.
REQ-013 SHALL have port mode_state  output  3  current FSM state encoding.
REQ-014 SHALL have port alarm_out  output  1  alarm indication; present only when CLOCK_SET_CTRL_ALARM_EN is defined.

Function
REQ-015 SHALL detect rising edges of mode_btn and inc_btn against a registered previous value, so each edge acts exactly once, one cycle after the input rises.
REQ-016 SHALL implement states RUN=0, SET_HOUR=1, SET_MIN=2, ALM_HOUR=3, ALM_MIN=4.
REQ-017 SHALL on a mode edge move RUN->SET_HOUR, SET_HOUR->SET_MIN, SET_MIN->RUN (alarm disabled) or SET_MIN->ALM_HOUR (alarm enabled), ALM_HOUR->ALM_MIN, ALM_MIN->RUN.
REQ-018 SHALL on RUN->SET_HOUR copy the hour and minute fields of cur_time into shadow registers in the same cycle.
REQ-019 SHALL assert clk_hold in SET_HOUR and SET_MIN only.
REQ-020 SHALL on an inc edge increment the shadow hour in SET_HOUR (BCD, 23->00), the shadow minute in SET_MIN (59->00), the alarm hour in ALM_HOUR and the alarm minute in ALM_MIN, with the same wrap rules; inc in RUN SHALL be ignored.
REQ-021 SHALL on leaving SET_MIN via a mode edge pulse load for exactly one cycle with load_time = {shadow hour, shadow min, 00}, and drop clk_hold in that same cycle.
REQ-022 SHALL hold load_time at the last loaded value otherwise, with 00:00:00 after reset.
REQ-023 SHALL, when mode and inc edges arrive in the same cycle, apply mode and discard inc.
REQ-024 SHALL in any non-RUN state count one_sec_pulse, clear the count on any button edge or state change, and on reaching AUTO_EXIT_SECS go to RUN without a load pulse, discarding shadow edits.
REQ-025 SHALL drive disp_time with cur_time in RUN, {shadow hour, shadow min, 00} in SET states and {alarm hour, alarm min, 00} in ALM states.
REQ-026 SHALL hold blink at 0 in RUN, set it to 1 on entry to any non-RUN state, and toggle it on each one_sec_pulse while in a non-RUN state.
REQ-027 SHALL keep every output registered, with no combinational path from an input to load or clk_hold.

Reset
REQ-028 SHALL on reset force state RUN, load=0, clk_hold=0, blink=0, load_time=0, shadow registers=00:00, timeout count=0, button history=0, alarm time=06:00 and alarm_out=0.
REQ-029 SHALL let reset asserted mid-edit abort the edit with no load pulse and take priority over every other event.

Configuration
REQ-030 SHALL, with CLOCK_SET_CTRL_ALARM_EN defined, include the ALM states, alarm registers and alarm_out; alarm_out sets in RUN on a one_sec_pulse cycle when cur_time equals {alarm hh, alarm mm, 00}.
REQ-031 SHALL clear alarm_out on the next button edge, and that edge SHALL cause no state change.
REQ-032 SHALL, without CLOCK_SET_CTRL_ALARM_EN, omit the ALM states, alarm registers and the alarm_out port, and use SET_MIN->RUN.

Verification
REQ-033 SHALL cover: cur_time=12:34:56, mode, 3x inc, mode, 2x inc, mode -> one load pulse with load_time=15:36:00; clk_hold high only between the first and last edge.
REQ-034 SHALL cover: shadow hour 23 + inc -> 00; shadow min 59 + inc -> 00; hour unchanged by minute wrap.
REQ-035 SHALL cover: AUTO_EXIT_SECS=3, enter SET_HOUR, 3 one_sec_pulse with no buttons -> state RUN, no load pulse, clk_hold=0.
REQ-036 SHALL cover: mode and inc rising in the same cycle in SET_HOUR -> state SET_MIN, shadow hour unchanged.
REQ-037 SHALL cover: reset asserted in SET_MIN -> next cycle state RUN, load=0, clk_hold=0, blink=0.
REQ-038 SHALL cover (ALARM_EN): alarm set to 06:01, cur_time reaches 06:01:00 with one_sec_pulse -> alarm_out=1; an inc edge clears it and state stays RUN.
